// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// Performs a sub-word store as a read-modify-write against a 32-bit,
// word-addressed memory. The byte or halfword taken from the low end of WrData
// is inserted into the existing memory word. Lane order is big-endian, so byte
// offset 0 occupies bits [31:24]. Word stores skip the read and are written
// directly.
//
// Ports
//   Clk          in   system clock, rising edge
//   Rst_n        in   asynchronous active-low reset
//   Req          in   start one store (sampled only while idle)
//   Addr[31:0]   in   byte address of the store
//   WrData[31:0] in   store source (byte uses [7:0], half uses [15:0])
//   Size[1:0]    in   00 byte, 01 half, 10 word, 11 reserved
//   MemAddr      out  word-aligned memory address (0 while idle)
//   MemRead      out  read strobe; MemReadData is valid the following cycle
//   MemReadData  in   memory read word
//   MemWrite     out  single-cycle write strobe
//   MemWriteData out  merged word to write
//   ByteEn[3:0]  out  lanes replaced, bit 3 = bits [31:24]
//   Busy         out  high whenever not idle
//   Done         out  single-cycle pulse, coincident with MemWrite
//   MisalignErr  out  single-cycle pulse after a rejected request
// -----------------------------------------------------------------------------
module store_merge_unit (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Req,
   input  logic [31:0] Addr,
   input  logic [31:0] WrData,
   input  logic [1:0]  Size,
   output logic [31:0] MemAddr,
   output logic        MemRead,
   input  logic [31:0] MemReadData,
   output logic        MemWrite,
   output logic [31:0] MemWriteData,
   output logic [3:0]  ByteEn,
   output logic        Busy,
   output logic        Done,
   output logic        MisalignErr
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_MERGE = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_err;
   logic [29:0] r_waddr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;

   logic        w_legal;
   logic        w_accept;
   logic [3:0]  w_be;
   logic [31:0] w_ins;

   // Keep the enabled lanes from the insert word, all others from the old word.
   function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                           input logic [31:0] ins_word,
                                           input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++)
         res[8*i +: 8] = be[i] ? ins_word[8*i +: 8] : old_word[8*i +: 8];
      return res;
   endfunction

   // Request decode. The sub-word is replicated across every lane so that
   // ByteEn alone selects where it lands; no shifter is needed.
   always_comb begin
      w_legal = 1'b0;
      w_be    = 4'b0000;
      w_ins   = 32'h0;
      case (Size)
         2'b00: begin
            w_legal = 1'b1;
            w_be    = 4'b1000 >> Addr[1:0];
            w_ins   = {4{WrData[7:0]}};
         end
         2'b01: begin
            w_legal = ~Addr[0];
            w_be    = Addr[1] ? 4'b0011 : 4'b1100;
            w_ins   = {2{WrData[15:0]}};
         end
         2'b10: begin
            w_legal = (Addr[1:0] == 2'b00);
            w_be    = 4'b1111;
            w_ins   = WrData;
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   assign w_accept = (r_state == ST_IDLE) && Req && w_legal;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_next = (Size == 2'b10) ? ST_WRITE : ST_READ;
         ST_READ:  w_next = ST_MERGE;
         ST_MERGE: w_next = ST_WRITE;
         ST_WRITE: w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Control state: reset asynchronously so every strobe drops at once.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= ST_IDLE;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= (r_state == ST_IDLE) && Req && !w_legal;
      end
   end

   // Datapath: not reset; every output derived from it is gated by state.
   always_ff @(posedge Clk) begin
      if (w_accept) begin
         r_waddr <= Addr[31:2];
         r_wdata <= w_ins;
         r_be    <= w_be;
      end else if (r_state == ST_MERGE) begin
         r_wdata <= f_merge(MemReadData, r_wdata, r_be);
      end
   end

   assign Busy         = (r_state != ST_IDLE);
   assign MemRead      = (r_state == ST_READ);
   assign MemWrite     = (r_state == ST_WRITE);
   assign Done         = (r_state == ST_WRITE);
   assign MisalignErr  = r_err;
   assign MemAddr      = Busy     ? {r_waddr, 2'b00} : 32'h0;
   assign MemWriteData = MemWrite ? r_wdata          : 32'h0;
   assign ByteEn       = MemWrite ? r_be             : 4'b0000;

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Req = 1'b0;
   logic [31:0] Addr = 32'h0;
   logic [31:0] WrData = 32'h0;
   logic [1:0]  Size = 2'b00;
   logic [31:0] MemAddr;
   logic        MemRead;
   logic [31:0] MemReadData = 32'hBAD0BAD0;
   logic        MemWrite;
   logic [31:0] MemWriteData;
   logic [3:0]  ByteEn;
   logic        Busy;
   logic        Done;
   logic        MisalignErr;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] rd_val = 32'h0;
   logic        rd_seen = 1'b0;

   // Scoreboard entry: {MemAddr, MemWriteData, ByteEn}
   logic [67:0] sb_q[$];

   store_merge_unit dut (
      .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Addr(Addr), .WrData(WrData),
      .Size(Size), .MemAddr(MemAddr), .MemRead(MemRead),
      .MemReadData(MemReadData), .MemWrite(MemWrite),
      .MemWriteData(MemWriteData), .ByteEn(ByteEn), .Busy(Busy),
      .Done(Done), .MisalignErr(MisalignErr)
   );

   always #5 Clk = ~Clk;

   // Memory model: read data is valid only in the cycle after MemRead.
   always @(negedge Clk) rd_seen = MemRead;
   always @(posedge Clk) begin
      #1;
      MemReadData = rd_seen ? rd_val : 32'hBAD0BAD0;
   end

   function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] s);
      case (s)
         2'b00: model_be = (a[1:0] == 2'd0) ? 4'b1000 : (a[1:0] == 2'd1) ? 4'b0100 :
                           (a[1:0] == 2'd2) ? 4'b0010 : 4'b0001;
         2'b01: model_be = (a[1:0] == 2'd0) ? 4'b1100 : 4'b0011;
         default: model_be = 4'b1111;
      endcase
   endfunction

   // Big-endian lane model: lane L (offset L) is bits [31-8L -: 8].
   function automatic logic [31:0] model_word(input logic [31:0] a, input logic [1:0] s,
                                              input logic [31:0] wd, input logic [31:0] rv);
      logic [31:0] r;
      int off;
      r = rv;
      off = int'(a[1:0]);
      case (s)
         2'b00: r[31-8*off -: 8] = wd[7:0];
         2'b01: begin
            r[31-8*off -: 8]     = wd[15:8];
            r[31-8*(off+1) -: 8] = wd[7:0];
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   task automatic do_store(input logic [31:0] a, input logic [1:0] s,
                           input logic [31:0] wd, input logic [31:0] rv);
      logic [67:0] e;
      logic [31:0] held;
      bit          got;
      int          rd_cyc, wr_cyc, n_rd, n_wr;
      @(negedge Clk);
      Req = 1'b1; Addr = a; Size = s; WrData = wd; rd_val = rv;
      sb_q.push_back({{a[31:2], 2'b00}, model_word(a, s, wd, rv), model_be(a, s)});
      @(negedge Clk);
      Req = 1'b0; Addr = $urandom; WrData = $urandom; Size = 2'($urandom_range(0, 3));
      rd_cyc = -1; wr_cyc = -1; n_rd = 0; n_wr = 0; got = 0; held = 32'h0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) @(negedge Clk);
         n_cmp++;
         if ((int'(MemRead) + int'(MemWrite) + int'(MisalignErr)) > 1 || Done !== MemWrite) begin
            n_bad++;
            $display("FAIL strobes cyc%0d: rd=%b wr=%b done=%b err=%b", c, MemRead, MemWrite, Done, MisalignErr);
         end
         if (Busy) begin
            if (!got) begin held = MemAddr; got = 1; end
            else begin
               n_cmp++;
               if (MemAddr !== held) begin
                  n_bad++;
                  $display("FAIL memaddr_hold cyc%0d: got %h need %h", c, MemAddr, held);
               end
            end
         end
         if (MemRead) begin n_rd++; if (rd_cyc < 0) rd_cyc = c; end
         if (MemWrite) begin
            n_wr++;
            if (wr_cyc < 0) wr_cyc = c;
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write cyc%0d: data %h", c, MemWriteData);
            end else begin
               e = sb_q.pop_front();
               if ({MemAddr, MemWriteData, ByteEn} !== e) begin
                  n_bad++;
                  $display("FAIL write_word a=%h s=%b: got %h/%h/%b need %h/%h/%b", a, s,
                           MemAddr, MemWriteData, ByteEn, e[67:36], e[35:4], e[3:0]);
               end
            end
         end
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL write_timeout a=%h: %0d pending need 0", a, sb_q.size());
         sb_q.delete();
      end
      n_cmp++;
      if (s == 2'b10) begin
         if (n_rd != 0 || wr_cyc != 1 || n_wr != 1) begin
            n_bad++;
            $display("FAIL word_latency: reads %0d wr_cyc %0d writes %0d need 0/1/1", n_rd, wr_cyc, n_wr);
         end
      end else begin
         if (n_rd != 1 || rd_cyc != 1 || wr_cyc != 3 || n_wr != 1) begin
            n_bad++;
            $display("FAIL sub_latency: reads %0d rd_cyc %0d wr_cyc %0d writes %0d need 1/1/3/1",
                     n_rd, rd_cyc, wr_cyc, n_wr);
         end
      end
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if ({Busy, MemRead, MemWrite, Done, MisalignErr} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b need 00000", {Busy, MemRead, MemWrite, Done, MisalignErr});
      end
      n_cmp++;
      if ({MemAddr, MemWriteData, ByteEn} !== 68'h0) begin
         n_bad++;
         $display("FAIL reset_data: got %h/%h/%b need 0", MemAddr, MemWriteData, ByteEn);
      end
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_byte();
      do_store(32'h00000101, 2'b00, 32'h123456AB, 32'h11223344);
      do_store(32'h00000100, 2'b00, 32'h000000C1, 32'h55667788);
      do_store(32'h00000102, 2'b00, 32'hFFFFFF02, 32'h55667788);
      do_store(32'h00000103, 2'b00, 32'h12345677, 32'hA0B0C0D0);
   endtask

   task automatic test_half();
      do_store(32'h00000202, 2'b01, 32'hFFFFBEEF, 32'hAABBCCDD);
      do_store(32'h00000300, 2'b01, 32'h00001234, 32'hAABBCCDD);
   endtask

   task automatic test_word();
      do_store(32'h00000010, 2'b10, 32'hDEADBEEF, 32'h01020304);
   endtask

   task automatic test_misalign(input logic [31:0] a, input logic [1:0] s);
      int strobes;
      @(negedge Clk);
      Req = 1'b1; Addr = a; Size = s; WrData = 32'hCAFEF00D;
      @(negedge Clk);
      Req = 1'b0;
      n_cmp++;
      if (MisalignErr !== 1'b1 || Busy !== 1'b0) begin
         n_bad++;
         $display("FAIL misalign_pulse a=%h s=%b: err=%b busy=%b need 1/0", a, s, MisalignErr, Busy);
      end
      strobes = 0;
      for (int c = 2; c <= 5; c++) begin
         @(negedge Clk);
         if (MisalignErr || Busy || MemRead || MemWrite) strobes++;
      end
      n_cmp++;
      if (strobes != 0) begin
         n_bad++;
         $display("FAIL misalign_quiet a=%h s=%b: %0d active cycles need 0", a, s, strobes);
      end
   endtask

   task automatic test_reset_abort();
      int writes;
      @(negedge Clk);
      Req = 1'b1; Addr = 32'h00000401; Size = 2'b00; WrData = 32'h000000EE; rd_val = 32'h12345678;
      @(negedge Clk);
      Req = 1'b0;
      @(negedge Clk);
      #2;
      Rst_n = 1'b0;
      #1;
      n_cmp++;
      if (Busy !== 1'b0 || MemAddr !== 32'h0) begin
         n_bad++;
         $display("FAIL async_reset: busy=%b addr=%h need 0/0", Busy, MemAddr);
      end
      writes = 0;
      repeat (3) begin
         @(negedge Clk);
         if (MemWrite || Done) writes++;
      end
      Rst_n = 1'b1;
      repeat (3) begin
         @(negedge Clk);
         if (MemWrite || Done) writes++;
      end
      n_cmp++;
      if (writes != 0) begin
         n_bad++;
         $display("FAIL abort_nowrite: %0d writes need 0", writes);
      end
      do_store(32'h00000500, 2'b00, 32'h0000005A, 32'h00000000);
   endtask

   task automatic test_back_to_back();
      int writes;
      bit busy_late;
      @(negedge Clk);
      Req = 1'b1; Addr = 32'h00000602; Size = 2'b01; WrData = 32'h0000A55A; rd_val = 32'h01234567;
      sb_q.push_back({32'h00000600, 32'h0123A55A, 4'b0011});
      writes = 0; busy_late = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clk);
         if (c <= 3) begin Addr = 32'h00000700; WrData = 32'hFFFFFFFF; end
         if (c == 4) Req = 1'b0;
         if (c >= 4 && Busy) busy_late = 1;
         if (MemWrite) begin
            writes++;
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL b2b_extra_write: data %h", MemWriteData);
            end else begin
               logic [67:0] e;
               e = sb_q.pop_front();
               if ({MemAddr, MemWriteData, ByteEn} !== e) begin
                  n_bad++;
                  $display("FAIL b2b_word: got %h/%h/%b need %h/%h/%b", MemAddr, MemWriteData,
                           ByteEn, e[67:36], e[35:4], e[3:0]);
               end
            end
         end
      end
      n_cmp++;
      if (writes != 1 || busy_late) begin
         n_bad++;
         $display("FAIL b2b_single: writes %0d busy_after %b need 1/0", writes, busy_late);
      end
      sb_q.delete();
      do_store(32'h00000800, 2'b10, 32'h89ABCDEF, 32'h0);
   endtask

   initial begin
      test_reset();
      test_byte();
      test_half();
      test_word();
      test_misalign(32'h00000003, 2'b01);
      test_misalign(32'h00000020, 2'b11);
      test_misalign(32'h00000022, 2'b10);
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: time %0t need finish", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL have port: Clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: Rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: Req  input  1  start one store; sampled only in IDLE.
REQ-004 SHALL have port: Addr  input  32  byte address of store.
REQ-005 SHALL have port: WrData  input  32  store source register; byte uses [7:0], half uses [15:0].
REQ-006 SHALL have port: Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL have port: MemAddr  output  32  word-aligned memory address, {Addr[31:2],2'b00}.
REQ-008 SHALL have port: MemRead  output  1  memory read strobe; MemReadData valid the following cycle.
REQ-009 SHALL have port: MemReadData  input  32  memory read word.
REQ-010 SHALL have port: MemWrite  output  1  memory write strobe, one cycle.
REQ-011 SHALL have port: MemWriteData  output  32  merged word to write.
REQ-012 SHALL have port: ByteEn  output  4  lanes replaced, bit 3 = bits [31:24].
REQ-013 SHALL have port: Busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port: Done  output  1  one-cycle pulse, coincident with MemWrite.
REQ-015 SHALL have port: MisalignErr  output  1  one-cycle pulse on rejected request.

Function
REQ-016 SHALL implement the narrowing/insert inverse of load extension: sub-word of WrData inserted into an existing memory word; big-endian lane order (offset 0 = bits [31:24]).
REQ-017 SHALL implement FSM states IDLE, READ, MERGE, WRITE.
REQ-018 IDLE: Req=1 with legal, aligned request SHALL latch Addr, WrData, Size; word -> WRITE, byte/half -> READ.
REQ-019 READ SHALL assert MemRead for exactly one cycle, then -> MERGE.
REQ-020 MERGE SHALL capture MemReadData, replace selected lanes with latched data, then -> WRITE.
REQ-021 WRITE SHALL assert MemWrite and Done for one cycle with MemWriteData and ByteEn valid, then -> IDLE.
REQ-022 Lane rules: byte offset k replaces bits [31-8k:24-8k] with WrData[7:0], ByteEn one-hot bit 3-k; half offset 0 -> [31:16], offset 2 -> [15:0] with WrData[15:0], ByteEn 1100/0011; word -> WrData unchanged, ByteEn 1111, no read.
REQ-023 Latency from Req cycle: word MemWrite +1 cycle; byte/half MemRead +1, MemWrite +3.
REQ-024 Misaligned (half with Addr[0]=1, word with Addr[1:0]!=0) or Size=11 SHALL pulse MisalignErr next cycle, stay IDLE, issue no MemRead/MemWrite.
REQ-025 Req while Busy SHALL be ignored (no queueing); Req in the cycle WRITE returns to IDLE is ignored, accepted from next IDLE cycle.
REQ-026 MemAddr SHALL hold constant from READ (or WRITE for word) through WRITE; 0 in IDLE.
REQ-027 MemRead, MemWrite, Done, MisalignErr SHALL never be high simultaneously.

Reset
REQ-028 Rst_n low SHALL immediately force IDLE and all outputs to 0 (MemAddr, MemWriteData, ByteEn = 0), regardless of clock.
REQ-029 Reset mid-operation SHALL abort the store with no MemWrite issued; first request after release is accepted normally.

Verification
REQ-030 Byte: Addr=0x00000101, Size=00, WrData=0x123456AB, MemReadData=0x11223344 -> MemRead at +1, MemWriteData=0x11AB3344, ByteEn=0100, Done at +3.
REQ-031 Half: Addr=0x00000202, Size=01, WrData=0xFFFFBEEF, MemReadData=0xAABBCCDD -> MemAddr=0x00000200, MemWriteData=0xAABBBEEF, ByteEn=0011.
REQ-032 Word: Addr=0x00000010, Size=10, WrData=0xDEADBEEF -> MemWrite+Done at +1, MemRead never high, ByteEn=1111.
REQ-033 Misalign: Size=01, Addr=0x00000003 -> MisalignErr pulse at +1, Busy stays 0, no memory strobes; Size=11 likewise.
REQ-034 Rst_n low during MERGE -> Busy=0 asynchronously, no MemWrite; second Req during Busy produces no extra store.
